seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
- Multi-cycle control unit for the 8-bit processor.
- Owns PC and IR. Runs FETCH/DECODE/EXEC/MEM, drives the 3-bit immediate into the sign-extension unit and consumes its 8-bit result.
- Issues register-file, ALU and memory control to the datapath.
- Instruction format: op[7:5], rd[4:3], imm3[2:0].

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- PC_W, 8, PC/address width (fixed at 8 for this ISA; parameterised for the pc_unit only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  8  PC in FETCH, imm_ext in MEM.
- mem_rdata  in  8  read data, valid on mem_ack.
- mem_ack  in  1  request complete, sampled on clk edge while mem_req=1.
- imm_bits  out  3  always equals ir[2:0]; to the sign-extension unit.
- imm_ext  in  8  sign-extended immediate, combinational from imm_bits.
- rf_sel  out  2  register select, equals ir[4:3].
- rf_we  out  1  register write enable, single-cycle pulse.
- wb_sel  out  2  write-back source: 0=ALU, 1=imm_ext, 2=mem_rdata.
- alu_op  out  2  0=PASS, 1=ADD (rd + imm_ext).
- rd_zero  in  1  datapath flag: selected register == 0.
- pc  out  8  current PC.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async):
  - state=FETCH, pc=RESET_PC, ir=8'h00 (NOP).
  - All outputs 0 except pc and mem_addr=RESET_PC.
  - Reset mid-request drops mem_req immediately; any later ack is ignored.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: ir<=mem_rdata, pc<=pc+1 (mod 256), go to DECODE.
  - No ack: hold, all outputs stable.
- DECODE:
  - One cycle; imm_ext settles and rd_zero becomes valid. Go to EXEC.
- EXEC, by opcode:
  - 000 NOP: go to FETCH.
  - 001 LDI: rf_we=1, wb_sel=1; go to FETCH.
  - 010 ADDI: rf_we=1, wb_sel=0, alu_op=1; go to FETCH.
  - 011 LD / 100 ST: go to MEM.
  - 101 BEQZ: if rd_zero then pc<=pc+imm_ext (pc already incremented, so target = instr_addr+1+sext). Go to FETCH.
  - 110 JMP: pc<=pc+imm_ext unconditionally; go to FETCH.
  - 111 HALT: go to HALT.
- MEM:
  - mem_req=1, mem_addr=imm_ext (range 8'hFC..8'h03), mem_we=1 for ST.
  - On mem_ack: LD pulses rf_we=1 with wb_sel=2 in the ack cycle; ST writes nothing. Go to FETCH.
- HALT: halted=1, no requests; exit only via rst.
- Latency with single-cycle ack: non-memory instructions 3 cycles; LD/ST 4 cycles; each added wait cycle adds 1.
- Arithmetic:
  - All PC arithmetic is 8-bit modulo 256. 8'hFF+1 wraps to 8'h00; branch below 0 wraps to 8'hFx.
- Handshake rules:
  - mem_ack while mem_req=0 is ignored.
  - mem_req never deasserts before ack except on reset.
  - rf_we is never asserted outside EXEC/MEM-ack.

Optional Feature:
- Macro: SEQ_CTRL_INSTR_COUNT_EN.
- Defined:
  - Adds output retired_cnt[15:0], reset 0.
  - Increments once per completed instruction (FETCH entry from EXEC or MEM). HALT is not counted.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package seq_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, HALT);
  - opcode enum (NOP..HALT);
  - WB_ALU/WB_IMM/WB_MEM constants;
  - ALU_PASS/ALU_ADD constants;
  - field position constants for op, rd and imm.
- One sub-module, pc_unit: PC register with reset load, increment and add-offset (imm_ext) controls.

Test Plan:
- Reset then memory returns 8'h25 (LDI r0,-3) with 1-cycle ack → rf_we pulse in EXEC, wb_sel=1, imm_bits=3'b101; pc=8'h01 after 3 cycles.
- BEQZ r1,-2 (8'hAE) at pc=8'h10 with rd_zero=1 → pc=8'h0F. Same instruction with rd_zero=0 → pc=8'h11.
- JMP +3 (8'hC3) at pc=8'hFE → pc wraps to 8'h02.
- LD r2,-1 (8'h77) with ack delayed 3 cycles → mem_addr=8'hFF and mem_req held 3 cycles; rf_we single pulse with wb_sel=2 in the ack cycle. ST (8'h81) → mem_we=1, no rf_we.
- Assert rst during a FETCH wait → mem_req drops immediately; pc=RESET_PC; late ack ignored; next fetch from RESET_PC.
- HALT (8'hE0) → halted=1 and stays high, no mem_req for 20 cycles. With SEQ_CTRL_INSTR_COUNT_EN, a run of 5 instructions + HALT gives retired_cnt=5.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the seq_ctrl multi-cycle control unit.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LD   = 3'd3,
    OP_ST   = 3'd4,
    OP_BEQZ = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;

  // Instruction layout: op[7:5], rd[4:3], imm3[2:0]
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 5;
  localparam int unsigned RD_MSB  = 4;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned IMM_MSB = 2;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic is_mem_op(opcode_t op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Memory request/acknowledge bus between seq_ctrl (master) and memory (slave).
interface seq_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/seq_ctrl_pc_unit.sv
// Program counter: reset load, post-fetch increment, relative add of an offset.
module pc_unit #(
  parameter int unsigned           PC_W     = 8,
  parameter logic [PC_W-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            add_en,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end else if (add_en) begin
      pc <= pc + offset;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer owning PC and IR.
// Optional SEQ_CTRL_INSTR_COUNT_EN adds a saturating retired-instruction counter.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  seq_ctrl_if.master      mem,
  output logic [2:0]      imm_bits,
  input  logic [7:0]      imm_ext,
  output logic [1:0]      rf_sel,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [1:0]      alu_op,
  input  logic            rd_zero,
  output logic [PC_W-1:0] pc,
`ifdef SEQ_CTRL_INSTR_COUNT_EN
  output logic [15:0]     retired_cnt,
`endif
  output logic            halted
);

  state_t     state;
  logic [7:0] ir;
  opcode_t    op;
  logic       fetch_done;
  logic       pc_add;

  assign op         = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign fetch_done = (state == S_FETCH) && mem.mem_ack;
  assign pc_add     = (state == S_EXEC) &&
                      ((op == OP_JMP) || ((op == OP_BEQZ) && rd_zero));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (mem.mem_ack) begin
          ir    <= mem.mem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (is_mem_op(op))      state <= S_MEM;
          else if (op == OP_HALT) state <= S_HALT;
          else                    state <= S_FETCH;
        end
        S_MEM:  if (mem.mem_ack) state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (fetch_done),
    .add_en (pc_add),
    .offset (imm_ext),
    .pc     (pc)
  );

  // Outputs decode registered state/IR; only the LD write-back is ack-qualified.
  // rst gates mem_req because the reset state is FETCH, which otherwise requests.
  assign mem.mem_req  = !rst && ((state == S_FETCH) || (state == S_MEM));
  assign mem.mem_we   = (state == S_MEM) && (op == OP_ST);
  assign mem.mem_addr = (state == S_MEM) ? imm_ext : pc;

  assign imm_bits = ir[IMM_MSB:IMM_LSB];
  assign rf_sel   = ir[RD_MSB:RD_LSB];
  assign halted   = (state == S_HALT);

  always_comb begin
    rf_we  = 1'b0;
    wb_sel = WB_ALU;
    alu_op = ALU_PASS;
    if (state == S_EXEC) begin
      if (op == OP_LDI) begin
        rf_we  = 1'b1;
        wb_sel = WB_IMM;
      end else if (op == OP_ADDI) begin
        rf_we  = 1'b1;
        alu_op = ALU_ADD;
      end
    end else if ((state == S_MEM) && (op == OP_LD)) begin
      wb_sel = WB_MEM;
      rf_we  = mem.mem_ack;
    end
  end

`ifdef SEQ_CTRL_INSTR_COUNT_EN
  logic retire;

  assign retire = ((state == S_EXEC) && !is_mem_op(op) && (op != OP_HALT)) ||
                  ((state == S_MEM) && mem.mem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (retire && (retired_cnt != '1)) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed ISA cases plus random programs against a PC/timing model.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] imm_bits;
  logic [7:0] imm_ext;
  logic [1:0] rf_sel;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic [1:0] alu_op;
  logic       rd_zero = 1'b0;
  logic [7:0] pc;
  logic       halted;
`ifdef SEQ_CTRL_INSTR_COUNT_EN
  logic [15:0] retired_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned mpc      = 0;
  int unsigned retired  = 0;

  always #5 clk = ~clk;

  seq_ctrl_if bus ();

  // External sign-extension unit
  always_comb imm_ext = {{5{imm_bits[2]}}, imm_bits};

  seq_ctrl #(
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus),
    .imm_bits    (imm_bits),
    .imm_ext     (imm_ext),
    .rf_sel      (rf_sel),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .rd_zero     (rd_zero),
    .pc          (pc),
`ifdef SEQ_CTRL_INSTR_COUNT_EN
    .retired_cnt (retired_cnt),
`endif
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    #1;
    check("r_req",  32'(bus.mem_req), 0);
    check("r_we",   32'(bus.mem_we), 0);
    check("r_addr", 32'(bus.mem_addr), 0);
    check("r_pc",   32'(pc), 0);
    check("r_rfwe", 32'(rf_we), 0);
    check("r_wb",   32'(wb_sel), 0);
    check("r_alu",  32'(alu_op), 0);
    check("r_imm",  32'(imm_bits), 0);
    check("r_sel",  32'(rf_sel), 0);
    check("r_halt", 32'(halted), 0);
`ifdef SEQ_CTRL_INSTR_COUNT_EN
    check("r_cnt",  32'(retired_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    mpc = 0;
    retired = 0;
  endtask

  // Runs one instruction through the DUT, with fwait/mwait extra ack-wait cycles.
  task automatic exec_one(input logic [7:0] instr, input logic rdz,
                          input int unsigned fwait, input int unsigned mwait);
    int unsigned op = 32'(instr[7:5]);
    int          s  = instr[2] ? int'(instr[2:0]) - 8 : int'(instr[2:0]);
    int unsigned ea = 32'((256 + s) % 256);

    for (int unsigned k = 0; k <= fwait; k++) begin
      @(negedge clk);
      bus.mem_ack   = (k == fwait);
      bus.mem_rdata = (k == fwait) ? instr : 8'($urandom);
      #1;
      check("f_req",  32'(bus.mem_req), 1);
      check("f_addr", 32'(bus.mem_addr), mpc);
      check("f_we",   32'(bus.mem_we), 0);
      check("f_rfwe", 32'(rf_we), 0);
    end

    @(negedge clk);
    bus.mem_ack = 1'($urandom);
    rd_zero = rdz;
    #1;
    check("d_req",  32'(bus.mem_req), 0);
    check("d_pc",   32'(pc), (mpc + 1) % 256);
    check("d_imm",  32'(imm_bits), 32'(instr[2:0]));
    check("d_sel",  32'(rf_sel), 32'(instr[4:3]));
    check("d_rfwe", 32'(rf_we), 0);

    @(negedge clk);
    bus.mem_ack = 1'($urandom);
    #1;
    check("x_rfwe", 32'(rf_we), (op == 1 || op == 2) ? 1 : 0);
    check("x_wb",   32'(wb_sel), (op == 1) ? 1 : 0);
    check("x_alu",  32'(alu_op), (op == 2) ? 1 : 0);
    check("x_req",  32'(bus.mem_req), 0);

    mpc = (mpc + 1) % 256;
    if (op == 6 || (op == 5 && rdz)) mpc = (mpc + 256 + 32'(s)) % 256;

    if (op == 3 || op == 4) begin
      for (int unsigned k = 0; k <= mwait; k++) begin
        @(negedge clk);
        bus.mem_ack   = (k == mwait);
        bus.mem_rdata = 8'($urandom);
        #1;
        check("m_req",  32'(bus.mem_req), 1);
        check("m_addr", 32'(bus.mem_addr), ea);
        check("m_we",   32'(bus.mem_we), (op == 4) ? 1 : 0);
        check("m_rfwe", 32'(rf_we), (op == 3 && k == mwait) ? 1 : 0);
        if (op == 3) check("m_wb", 32'(wb_sel), 2);
      end
    end

    if (op == 7) begin
      for (int unsigned k = 0; k < 20; k++) begin
        @(negedge clk);
        bus.mem_ack = 1'($urandom);
        #1;
        check("h_halt", 32'(halted), 1);
        check("h_req",  32'(bus.mem_req), 0);
        check("h_rfwe", 32'(rf_we), 0);
        check("h_pc",   32'(pc), mpc);
      end
    end else begin
      retired++;
    end
  endtask

  task automatic rand_instr(output logic [7:0] instr);
    instr = 8'($urandom);
    instr[7:5] = 3'($urandom_range(0, 6));
  endtask

  initial begin
    logic [7:0] ins;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;

    do_reset();
    exec_one(8'h25, 1'b0, 0, 0);          // LDI r0,-3

    do_reset();
    repeat (4) exec_one(8'hC3, 1'b0, 0, 0); // walk pc to 0x10
    exec_one(8'hAE, 1'b1, 0, 0);          // BEQZ taken -> 0x0F
    check("beqz_t", mpc, 32'h0F);
    exec_one(8'h00, 1'b0, 0, 0);
    exec_one(8'hAE, 1'b0, 0, 0);          // BEQZ not taken -> 0x11
    check("beqz_n", mpc, 32'h11);

    do_reset();
    exec_one(8'hC4, 1'b0, 0, 0);          // JMP -4 -> 0xFD
    exec_one(8'h00, 1'b0, 0, 0);
    exec_one(8'hC3, 1'b0, 0, 0);          // JMP +3 at 0xFE -> 0x02
    check("jmp_wrap", mpc, 32'h02);
    exec_one(8'h77, 1'b0, 1, 2);          // LD r2,-1, ack after 3 cycles
    exec_one(8'h81, 1'b0, 0, 0);          // ST

    // Reset while a fetch is waiting for ack
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("w_req", 32'(bus.mem_req), 1);
    #2 rst = 1'b1;
    #1;
    check("w_drop", 32'(bus.mem_req), 0);
    check("w_pc",   32'(pc), 0);
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hC3;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check("w_pc2",  32'(pc), 0);
    check("w_req2", 32'(bus.mem_req), 1);
    mpc = 0;
    retired = 0;
    exec_one(8'h25, 1'b0, 1, 0);

    for (int unsigned i = 0; i < 300; i++) begin
      rand_instr(ins);
      exec_one(ins, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    exec_one(8'hE0, 1'b0, 0, 0);

    do_reset();
    for (int unsigned i = 0; i < 5; i++) begin
      rand_instr(ins);
      exec_one(ins, 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    exec_one(8'hE0, 1'b0, 0, 0);
`ifdef SEQ_CTRL_INSTR_COUNT_EN
    check("cnt5", 32'(retired_cnt), retired);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
